// File: rtl/unit_clause_scan_pkg.sv
// Shared types for the unit-propagation scanner: literal/clause/formula layouts
// and the per-clause classification.
package unit_clause_scan_pkg;

  localparam int unsigned CFG_NUM_CLAUSES = 16;
  localparam int unsigned CFG_MAX_LITS    = 4;
  localparam int unsigned CFG_NUM_VARS    = 16;

  localparam int unsigned VAR_W = $clog2(CFG_NUM_VARS);
  localparam int unsigned IDX_W = $clog2(CFG_NUM_CLAUSES + 1);
  localparam int unsigned LEN_W = $clog2(CFG_MAX_LITS + 1);

  typedef struct packed {
    logic             neg;
    logic [VAR_W-1:0] vidx;
  } lit_t;

  typedef struct packed {
    logic [LEN_W-1:0]        len;
    lit_t [CFG_MAX_LITS-1:0] lits;
  } clause_t;

  typedef struct packed {
    logic [IDX_W-1:0]             len;
    clause_t [CFG_NUM_CLAUSES-1:0] clauses;
  } formula_t;

  localparam lit_t     LIT_ZERO     = '0;
  localparam clause_t  CLAUSE_ZERO  = '0;
  localparam formula_t FORMULA_ZERO = '0;

  typedef enum logic [1:0] {
    OPEN     = 2'd0,
    SAT      = 2'd1,
    UNIT     = 2'd2,
    CONFLICT = 2'd3
  } clause_class_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/unit_clause_scan_clause_eval.sv
// Combinational classifier for a single clause against a partial assignment.
module clause_eval
  import unit_clause_scan_pkg::*;
#(
  parameter int unsigned MAX_LITS = CFG_MAX_LITS,
  parameter int unsigned NUM_VARS = CFG_NUM_VARS
) (
  input  clause_t             clause,
  input  logic [NUM_VARS-1:0] assigned,
  input  logic [NUM_VARS-1:0] value,
  output clause_class_t       cls,
  output lit_t                unit_lit
);

  logic any_true;
  logic seen_one;
  logic seen_two;
  lit_t cur;

  always_comb begin
    any_true = 1'b0;
    seen_one = 1'b0;
    seen_two = 1'b0;
    unit_lit = LIT_ZERO;
    cur      = LIT_ZERO;
    cls      = OPEN;
    // Lengths above MAX_LITS fall out naturally: k never reaches them.
    for (int unsigned k = 0; k < MAX_LITS; k++) begin
      cur = clause.lits[k];
      if (k < 32'(clause.len)) begin
        if (assigned[cur.vidx]) begin
          if (value[cur.vidx] != cur.neg) any_true = 1'b1;
        end else begin
          seen_two = seen_two | seen_one;
          seen_one = 1'b1;
          unit_lit = cur;
        end
      end
    end
    if (any_true)       cls = SAT;
    else if (!seen_one) cls = CONFLICT;
    else if (!seen_two) cls = UNIT;
    else                cls = OPEN;
  end

endmodule

// File: rtl/unit_clause_scan.sv
// Unit-propagation scanner: evaluates LANES clauses per cycle over a snapshot
// and stops at the first unit or conflicting clause; `next` resumes after it.
module unit_clause_scan
  import unit_clause_scan_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES = CFG_NUM_CLAUSES,
  parameter int unsigned MAX_LITS    = CFG_MAX_LITS,
  parameter int unsigned NUM_VARS    = CFG_NUM_VARS,
  parameter int unsigned LANES       = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                next,
  input  formula_t            in_formula,
  input  logic [NUM_VARS-1:0] assigned,
  input  logic [NUM_VARS-1:0] value,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic                conflict,
  output lit_t                lit_found,
  output logic [IDX_W-1:0]    clause_idx
);

  localparam int unsigned CI_W  = $clog2(NUM_CLAUSES);
  localparam int unsigned SUM_W = IDX_W + 1;

  scan_state_t state, state_d;

  clause_t [NUM_CLAUSES-1:0] snap_clauses;
  logic [IDX_W-1:0]          snap_len;
  logic [NUM_VARS-1:0]       snap_assigned;
  logic [NUM_VARS-1:0]       snap_value;
  logic [IDX_W-1:0]          grp_base, grp_base_d;
  logic [IDX_W-1:0]          in_len_eff;

  logic             load_snap;
  logic             done_d, found_d, conflict_d;
  lit_t             lit_d;
  logic [IDX_W-1:0] idx_d;

  logic [SUM_W-1:0] lane_idx    [LANES];
  logic             lane_valid  [LANES];
  clause_t          lane_clause [LANES];
  clause_class_t    lane_class  [LANES];
  lit_t             lane_lit    [LANES];

  logic             hit, hit_unit;
  lit_t             hit_lit;
  logic [IDX_W-1:0] hit_idx;
  logic [SUM_W-1:0] grp_sum;
  logic             grp_last;
  logic [SUM_W-1:0] idx_plus;

  assign in_len_eff = (in_formula.len > IDX_W'(NUM_CLAUSES)) ? IDX_W'(NUM_CLAUSES)
                                                             : in_formula.len;

  // Lanes past the effective length are masked out before the priority encoder,
  // so their (zeroed, CONFLICT-looking) classification never matters.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_idx[g]    = {1'b0, grp_base} + SUM_W'(g);
    assign lane_valid[g]  = lane_idx[g] < {1'b0, snap_len};
    assign lane_clause[g] = lane_valid[g] ? snap_clauses[lane_idx[g][CI_W-1:0]] : CLAUSE_ZERO;

    clause_eval #(
      .MAX_LITS(MAX_LITS),
      .NUM_VARS(NUM_VARS)
    ) u_eval (
      .clause  (lane_clause[g]),
      .assigned(snap_assigned),
      .value   (snap_value),
      .cls     (lane_class[g]),
      .unit_lit(lane_lit[g])
    );
  end

  always_comb begin
    hit      = 1'b0;
    hit_unit = 1'b0;
    hit_lit  = LIT_ZERO;
    hit_idx  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (!hit && lane_valid[l] && (lane_class[l] == UNIT || lane_class[l] == CONFLICT)) begin
        hit      = 1'b1;
        hit_unit = (lane_class[l] == UNIT);
        hit_lit  = (lane_class[l] == UNIT) ? lane_lit[l] : LIT_ZERO;
        hit_idx  = lane_idx[l][IDX_W-1:0];
      end
    end
  end

  assign grp_sum  = {1'b0, grp_base} + SUM_W'(LANES);
  assign grp_last = grp_sum >= {1'b0, snap_len};
  assign idx_plus = {1'b0, clause_idx} + SUM_W'(1);
  assign busy     = (state == S_SCAN);

  always_comb begin
    state_d    = state;
    grp_base_d = grp_base;
    load_snap  = 1'b0;
    done_d     = 1'b0;
    found_d    = found;
    conflict_d = conflict;
    lit_d      = lit_found;
    idx_d      = clause_idx;
    unique case (state)
      S_IDLE: begin
        if (start || next) begin
          found_d    = 1'b0;
          conflict_d = 1'b0;
          lit_d      = LIT_ZERO;
          idx_d      = '0;
          if (start) begin
            state_d    = S_SCAN;
            grp_base_d = '0;
            load_snap  = 1'b1;
          end else if ((found || conflict) && (idx_plus < {1'b0, snap_len})) begin
            state_d    = S_SCAN;
            grp_base_d = idx_plus[IDX_W-1:0];
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (hit) begin
          found_d    = hit_unit;
          conflict_d = !hit_unit;
          lit_d      = hit_lit;
          idx_d      = hit_idx;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else if (grp_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          grp_base_d = grp_sum[IDX_W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      grp_base      <= '0;
      done          <= 1'b0;
      found         <= 1'b0;
      conflict      <= 1'b0;
      lit_found     <= LIT_ZERO;
      clause_idx    <= '0;
      snap_clauses  <= '0;
      snap_len      <= '0;
      snap_assigned <= '0;
      snap_value    <= '0;
    end else begin
      state      <= state_d;
      grp_base   <= grp_base_d;
      done       <= done_d;
      found      <= found_d;
      conflict   <= conflict_d;
      lit_found  <= lit_d;
      clause_idx <= idx_d;
      if (load_snap) begin
        snap_clauses  <= in_formula.clauses;
        snap_len      <= in_len_eff;
        snap_assigned <= assigned;
        snap_value    <= value;
      end
    end
  end

endmodule
